// File: rtl/tangram_pkg.sv
// Shared types and constants for the tangram command scheduler.
// Op encodings, queued command layout and VGA timing constants.
package tangram_pkg;

    localparam int H_TOTAL      = 1056;
    localparam int V_TOTAL      = 628;
    localparam int V_ACTIVE_DEF = 600;
    localparam int N_PIECE      = 7;

    typedef enum logic [2:0] {
        OP_ROT   = 3'd0,
        OP_UP    = 3'd1,
        OP_DOWN  = 3'd2,
        OP_LEFT  = 3'd3,
        OP_RIGHT = 3'd4
    } op_e;

    typedef struct packed {
        op_e        op;
        logic [2:0] piece;
    } cmd_t;

    // Keep only the lowest set bit.
    function automatic logic [6:0] lowest_bit(input logic [6:0] x);
        return x & (~x + 7'd1);
    endfunction

    // Index of the set bit in a one-hot (or zero) vector.
    function automatic logic [2:0] onehot_idx(input logic [6:0] x);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < N_PIECE; i++) begin
            if (x[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/tangram_cmd_sched_if.sv
// Bus bundle between key/timing logic and the scheduler.
// master drives timing, switches and keys; slave returns strobes.
interface tangram_cmd_sched_if;

    logic [10:0] hc;
    logic [10:0] vc;
    logic [6:0]  select;
    logic        rotate;
    logic [3:0]  move;
    logic [4:0]  move_lvl;
    logic [6:0]  active_sel;
    logic [6:0]  piece_rot;
    logic [3:0]  piece_move;
    logic [6:0]  piece_en;
    logic        overflow;

    modport master (
        output hc, vc, select, rotate, move, move_lvl,
        input  active_sel, piece_rot, piece_move, piece_en, overflow
    );

    modport slave (
        input  hc, vc, select, rotate, move, move_lvl,
        output active_sel, piece_rot, piece_move, piece_en, overflow
    );

endinterface

// File: rtl/tangram_cmd_fifo.sv
// Synchronous DEPTH x 6 command FIFO with full/empty flags.
// A write when full is accepted only if a read happens in the same cycle.
module tangram_cmd_fifo
    import tangram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  cmd_t                     wr_data,
    input  logic                     rd_en,
    output cmd_t                     rd_data,
    output logic                     wr_ok,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    cmd_t          mem_q [DEPTH];
    cmd_t          mem_d [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_rd;

    // Pointer, count and storage update.
    always_comb begin
        mem_d = mem_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        do_rd = rd_en && (cnt_q != '0);
        wr_ok = wr_en && ((cnt_q != FULL_CNT) || do_rd);
        if (wr_ok) begin
            mem_d[wp_q] = wr_data;
            wp_d        = wp_q + 1'b1;
        end
        if (do_rd) rp_d = rp_q + 1'b1;
        case ({wr_ok, do_rd})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    assign rd_data = mem_q[rp_q];
    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;

endmodule

// File: rtl/tangram_cmd_sched.sv
// Piece-select arbiter and vblank-aligned command scheduler.
// Optional key auto-repeat is enabled by defining TANGRAM_AUTOREPEAT_EN.
module tangram_cmd_sched
    import tangram_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int RPT_DELAY = 20,
    parameter int RPT_RATE  = 4
) (
    input  logic                  clk_40m,
    input  logic                  reset,
    tangram_cmd_sched_if.slave    bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PEND  = 2'd1;
    localparam logic [1:0] ISSUE = 2'd2;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]  state_q, state_d;
    logic [6:0]  active_sel_q, active_sel_d;
    logic        cap_vld_q, cap_vld_d;
    cmd_t        cap_q, cap_d;
    logic [6:0]  rot_q, rot_d;
    logic [6:0]  en_q, en_d;
    logic [3:0]  mv_q, mv_d;
    logic        ovf_q, ovf_d;
    logic        frame_tick;
    logic [4:0]  keys;
    logic        rd_en;
    cmd_t        head;
    logic        wr_ok;
    logic        f_full, f_empty;
    logic [CW-1:0] f_count;

    assign frame_tick = (bus.hc == '0) && (bus.vc == V_ACTIVE[10:0]);

`ifdef TANGRAM_AUTOREPEAT_EN
    localparam logic [4:0] RD = RPT_DELAY[4:0];
    localparam logic [4:0] RE = 5'(RPT_DELAY + RPT_RATE);

    logic [4:0] rpt_q [5];
    logic [4:0] rpt_d [5];
    logic [4:0] rpt_fire;

    // Per-key hold counters; fire at the delay, then every rate frames.
    always_comb begin
        rpt_fire = '0;
        for (int i = 0; i < 5; i++) begin
            rpt_d[i] = rpt_q[i];
            if (!bus.move_lvl[i]) begin
                rpt_d[i] = '0;
            end else if (frame_tick) begin
                rpt_d[i] = rpt_q[i] + 5'd1;
                if (rpt_d[i] == RD) begin
                    rpt_fire[i] = 1'b1;
                end else if (rpt_d[i] == RE) begin
                    rpt_fire[i] = 1'b1;
                    rpt_d[i]    = RD;
                end
            end
        end
    end

    // Hold counter registers.
    always_ff @(posedge clk_40m or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 5; i++) rpt_q[i] <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end

    assign keys = {bus.rotate, bus.move} | rpt_fire;
`else
    logic unused_lvl;
    assign unused_lvl = ^bus.move_lvl;
    assign keys = {bus.rotate, bus.move};
`endif

    // Selection arbitration and key priority capture.
    always_comb begin
        active_sel_d = lowest_bit(bus.select);
        cap_vld_d    = (|keys) && (|active_sel_q);
        cap_d.piece  = onehot_idx(active_sel_q);
        priority case (1'b1)
            keys[4]: cap_d.op = OP_ROT;
            keys[0]: cap_d.op = OP_UP;
            keys[1]: cap_d.op = OP_DOWN;
            keys[2]: cap_d.op = OP_LEFT;
            keys[3]: cap_d.op = OP_RIGHT;
            default: cap_d.op = OP_ROT;
        endcase
    end

    tangram_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk_40m),
        .rst     (reset),
        .wr_en   (cap_vld_q),
        .wr_data (cap_q),
        .rd_en   (rd_en),
        .rd_data (head),
        .wr_ok   (wr_ok),
        .full    (f_full),
        .empty   (f_empty),
        .count   (f_count)
    );

    // Issue FSM and per-piece strobe decode.
    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        rot_d   = '0;
        en_d    = '0;
        mv_d    = '0;
        ovf_d   = ovf_q | (cap_vld_q && !wr_ok);
        case (state_q)
            IDLE:    if (wr_ok) state_d = PEND;
            PEND:    if (frame_tick) state_d = ISSUE;
            ISSUE: begin
                rd_en = !f_empty;
                if (!f_empty) begin
                    unique case (head.op)
                        OP_ROT:   rot_d = 7'd1 << head.piece;
                        OP_UP:    mv_d  = 4'b0001;
                        OP_DOWN:  mv_d  = 4'b0010;
                        OP_LEFT:  mv_d  = 4'b0100;
                        OP_RIGHT: mv_d  = 4'b1000;
                        default:  mv_d  = 4'b0000;
                    endcase
                    if (head.op != OP_ROT) en_d = 7'd1 << head.piece;
                end
                if ((f_count > CW'(1)) || wr_ok) state_d = PEND;
                else state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Scheduler registers.
    always_ff @(posedge clk_40m or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            active_sel_q <= '0;
            cap_vld_q    <= 1'b0;
            cap_q        <= '0;
            rot_q        <= '0;
            en_q         <= '0;
            mv_q         <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_sel_q <= active_sel_d;
            cap_vld_q    <= cap_vld_d;
            cap_q        <= cap_d;
            rot_q        <= rot_d;
            en_q         <= en_d;
            mv_q         <= mv_d;
            ovf_q        <= ovf_d;
        end
    end

    assign bus.active_sel = active_sel_q;
    assign bus.piece_rot  = rot_q;
    assign bus.piece_en   = en_q;
    assign bus.piece_move = mv_q;
    assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_tangram_cmd_sched.sv
// Testbench for tangram_cmd_sched: scoreboard of expected strobes
// per frame tick, plus reset, overflow, retarget and hold-key cases.
`timescale 1ns/1ps
module tb_tangram_cmd_sched;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [17:0] exp_q [$];

    tangram_cmd_sched_if bus ();

    tangram_cmd_sched u_dut (
        .clk_40m (clk),
        .reset   (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic push_exp(input logic [6:0] r, input logic [6:0] e,
                            input logic [3:0] m);
        exp_q.push_back({r, e, m});
    endtask

    task automatic tick_check(input string name);
        logic [17:0] obs;
        logic [17:0] exp;
        int hits;
        obs  = '0;
        hits = 0;
        bus.hc = 11'd0;
        bus.vc = 11'd600;
        @(negedge clk);
        bus.hc = 11'd5;
        bus.vc = 11'd0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if ({bus.piece_rot, bus.piece_en, bus.piece_move} != '0) begin
                if (hits == 0)
                    obs = {bus.piece_rot, bus.piece_en, bus.piece_move};
                hits++;
            end
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 18'd0;
        checks++;
        if (obs !== exp || hits > 1) begin
            errors++;
            $display("FAIL %s rot/en/mv got %b/%b/%b cycles=%0d want %b/%b/%b",
                     name, obs[17:11], obs[10:4], obs[3:0], hits,
                     exp[17:11], exp[10:4], exp[3:0]);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.active_sel, bus.piece_rot, bus.piece_en,
             bus.piece_move, bus.overflow} !== 26'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0",
                     {bus.active_sel, bus.piece_rot, bus.piece_en,
                      bus.piece_move, bus.overflow});
        end
        rst = 1'b0;
        wait_cyc(3);
        checks++;
        if (bus.active_sel !== 7'd0) begin
            errors++;
            $display("FAIL idle_sel got %b want 0", bus.active_sel);
        end
        tick_check("empty_tick");
    endtask

    task automatic test_select_rotate();
        bus.select = 7'b0010100;
        wait_cyc(2);
        checks++;
        if (bus.active_sel !== 7'b0000100) begin
            errors++;
            $display("FAIL active_sel got %b want 0000100", bus.active_sel);
        end
        bus.rotate = 1'b1;
        push_exp(7'b0000100, 7'd0, 4'd0);
        @(negedge clk);
        bus.rotate = 1'b0;
        wait_cyc(3);
        tick_check("sel_rotate");
    endtask

    task automatic test_priority();
        bus.select = 7'b0000001;
        wait_cyc(2);
        bus.rotate = 1'b1;
        bus.move   = 4'b0001;
        push_exp(7'b0000001, 7'd0, 4'd0);
        @(negedge clk);
        bus.rotate = 1'b0;
        bus.move   = 4'd0;
        wait_cyc(3);
        tick_check("prio_rotate");
        tick_check("prio_single");
        bus.select = 7'b0000110;
        wait_cyc(2);
        bus.move = 4'b1110;
        push_exp(7'd0, 7'b0000010, 4'b0010);
        @(negedge clk);
        bus.move = 4'b1100;
        push_exp(7'd0, 7'b0000010, 4'b0100);
        @(negedge clk);
        bus.move = 4'd0;
        wait_cyc(3);
        tick_check("prio_down");
        tick_check("prio_left");
    endtask

    task automatic test_overflow();
        bus.select = 7'b0000010;
        wait_cyc(2);
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_before got %b want 0", bus.overflow);
        end
        for (int i = 0; i < 5; i++) begin
            bus.move = 4'b0001;
            if (i < 4) push_exp(7'd0, 7'b0000010, 4'b0001);
            @(negedge clk);
        end
        bus.move = 4'd0;
        wait_cyc(3);
        checks++;
        if (bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_after got %b want 1", bus.overflow);
        end
        for (int i = 0; i < 5; i++) tick_check("ovf_drain");
    endtask

    task automatic test_retarget();
        bus.select = 7'b0001000;
        wait_cyc(2);
        bus.move = 4'b0100;
        push_exp(7'd0, 7'b0001000, 4'b0100);
        @(negedge clk);
        bus.move   = 4'd0;
        bus.select = 7'b0100000;
        wait_cyc(3);
        tick_check("retarget");
    endtask

    task automatic test_reset_mid();
        bus.select = 7'b0000001;
        wait_cyc(2);
        for (int i = 0; i < 3; i++) begin
            bus.rotate = 1'b1;
            @(negedge clk);
            bus.rotate = 1'b0;
            @(negedge clk);
        end
        wait_cyc(2);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.active_sel, bus.piece_rot, bus.piece_en,
             bus.piece_move, bus.overflow} !== 26'd0) begin
            errors++;
            $display("FAIL reset_mid got %b want 0",
                     {bus.active_sel, bus.piece_rot, bus.piece_en,
                      bus.piece_move, bus.overflow});
        end
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(2);
        for (int i = 0; i < 3; i++) tick_check("after_reset");
    endtask

    task automatic test_hold_repeat();
        bus.select = 7'b0000001;
        wait_cyc(2);
        bus.move_lvl = 5'b01000;
        for (int f = 1; f <= 30; f++) begin
`ifdef TANGRAM_AUTOREPEAT_EN
            if (f == 21 || f == 25 || f == 29)
                push_exp(7'd0, 7'b0000001, 4'b1000);
`endif
            tick_check("hold_repeat");
        end
        bus.move_lvl = 5'd0;
        wait_cyc(2);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.hc       = 11'd5;
        bus.vc       = 11'd0;
        bus.select   = 7'd0;
        bus.rotate   = 1'b0;
        bus.move     = 4'd0;
        bus.move_lvl = 5'd0;
        wait_cyc(2);
        test_reset();
        test_select_rotate();
        test_priority();
        test_overflow();
        test_retarget();
        test_reset_mid();
        test_hold_repeat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
